// File: rtl/rs_pkg.sv
// Shared constants for the reservation station.
// SRC0 selects the low half of the packed dispatch source buses and feeds iss_a;
// SRC1 selects the high half and feeds iss_b.
package rs_pkg;
  localparam int SRC0    = 0;
  localparam int SRC1    = 1;
  localparam int NUM_SRC = 2;
endpackage

// File: rtl/rs_age_select.sv
// Age matrix with oldest-eligible select.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   disp_oh    - one-hot entry being written this cycle (zero when none)
//   free_oh    - one-hot entry being released this cycle (zero when none)
//   elig       - per-entry eligibility
//   oldest_oh  - one-hot oldest eligible entry
//   any_elig   - at least one entry is eligible
// age_q[i][j] = 1 means entry i is older than entry j.
module rs_age_select #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] disp_oh,
  input  logic [DEPTH-1:0] free_oh,
  input  logic [DEPTH-1:0] elig,
  output logic [DEPTH-1:0] oldest_oh,
  output logic             any_elig
);
  logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;

  always_comb begin
    age_d = age_q;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (free_oh[i]) begin
          age_d[i][j] = 1'b0;
          age_d[j][i] = 1'b0;
        end
      end
    end
    // A new entry is younger than everything already present.
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (disp_oh[i]) begin
          age_d[i][j] = 1'b0;
          age_d[j][i] = (i != j);
        end
      end
    end
  end

  always_comb begin
    oldest_oh = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic blocked;
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (elig[j] && age_q[j][i]) blocked = 1'b1;
      end
      oldest_oh[i] = elig[i] && !blocked;
    end
  end

  assign any_elig = |elig;

  always_ff @(posedge clk) begin
    if (rst) age_q <= '0;
    else     age_q <= age_d;
  end
endmodule

// File: rtl/reservation_station.sv
// Reservation station: buffers DEPTH dispatched operations, captures pending
// operands from the CDB, and issues the oldest ready operation to one FU.
// Ports:
//   clk, rst, flush                     - clock, sync active-high reset, discard-all
//   disp_valid/disp_ready + disp_*      - dispatch handshake and payload (src1 in high half)
//   cdb_valid/cdb_tag/cdb_data          - result broadcast bus
//   iss_valid/iss_ready + iss_*         - issue handshake and payload
//   occupancy                           - number of valid entries
module reservation_station
  import rs_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  parameter int TAG_W = 3,
  parameter int OP_W  = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [TAG_W-1:0]             disp_tag,
  input  logic [OP_W-1:0]              disp_op,
  input  logic [1:0]                   disp_src_rdy,
  input  logic [2*TAG_W-1:0]           disp_src_tag,
  input  logic [2*XLEN-1:0]            disp_src_val,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [XLEN-1:0]              cdb_data,
  output logic                         iss_valid,
  input  logic                         iss_ready,
  output logic [TAG_W-1:0]             iss_tag,
  output logic [OP_W-1:0]              iss_op,
  output logic [XLEN-1:0]              iss_a,
  output logic [XLEN-1:0]              iss_b,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
  localparam int OCC_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic             rdy;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  val;
  } src_t;

  typedef struct packed {
    logic                      valid;
    logic [TAG_W-1:0]          tag;
    logic [OP_W-1:0]           op;
    src_t [NUM_SRC-1:0]        src;
  } entry_t;

  entry_t             ent_q [DEPTH];
  entry_t             ent_d [DEPTH];
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               lock_q, lock_d;
  logic [DEPTH-1:0]   lock_oh_q, lock_oh_d;
  logic [DEPTH-1:0]   slot_oh, elig, oldest_oh, sel_oh;
  logic               any_elig, disp_fire, iss_fire;

  // Lowest-index free slot.
  always_comb begin
    slot_oh = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!ent_q[i].valid) slot_oh = DEPTH'(1) << i;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = ent_q[i].valid && ent_q[i].src[SRC0].rdy && ent_q[i].src[SRC1].rdy;
    end
  end

  rs_age_select #(.DEPTH(DEPTH)) u_age (
    .clk       (clk),
    .rst       (rst),
    .disp_oh   (disp_fire ? slot_oh : '0),
    .free_oh   (iss_fire ? sel_oh : '0),
    .elig      (elig),
    .oldest_oh (oldest_oh),
    .any_elig  (any_elig)
  );

  assign disp_ready = (occ_q < OCC_W'(DEPTH)) && !rst && !flush;
  assign disp_fire  = disp_valid && disp_ready;
  // A locked entry stays presented even if an older one becomes eligible.
  assign sel_oh     = lock_q ? lock_oh_q : oldest_oh;
  assign iss_valid  = lock_q || any_elig;
  assign iss_fire   = iss_valid && iss_ready && !flush;
  assign occupancy  = occ_q;

  // OR-mux over a one-hot select: payload reads zero when nothing is selected.
  always_comb begin
    iss_tag = '0;
    iss_op  = '0;
    iss_a   = '0;
    iss_b   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_oh[i]) begin
        iss_tag = iss_tag | ent_q[i].tag;
        iss_op  = iss_op  | ent_q[i].op;
        iss_a   = iss_a   | ent_q[i].src[SRC0].val;
        iss_b   = iss_b   | ent_q[i].src[SRC1].val;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      for (int s = 0; s < NUM_SRC; s++) begin
        if (ent_q[i].valid && !ent_q[i].src[s].rdy && cdb_valid &&
            cdb_tag == ent_q[i].src[s].tag) begin
          ent_d[i].src[s].rdy = 1'b1;
          ent_d[i].src[s].val = cdb_data;
        end
      end
      if (iss_fire && sel_oh[i]) ent_d[i].valid = 1'b0;
      if (disp_fire && slot_oh[i]) begin
        ent_d[i].valid = 1'b1;
        ent_d[i].tag   = disp_tag;
        ent_d[i].op    = disp_op;
        for (int s = 0; s < NUM_SRC; s++) begin
          ent_d[i].src[s].rdy = disp_src_rdy[s];
          ent_d[i].src[s].tag = disp_src_tag[s*TAG_W +: TAG_W];
          ent_d[i].src[s].val = disp_src_val[s*XLEN +: XLEN];
          // Same-cycle CDB bypass for a source that is still pending.
          if (!disp_src_rdy[s] && cdb_valid && cdb_tag == disp_src_tag[s*TAG_W +: TAG_W]) begin
            ent_d[i].src[s].rdy = 1'b1;
            ent_d[i].src[s].val = cdb_data;
          end
        end
      end
      if (flush) ent_d[i].valid = 1'b0;
    end
  end

  always_comb begin
    lock_d    = lock_q;
    lock_oh_d = lock_oh_q;
    if (flush) begin
      lock_d = 1'b0;
    end else if (iss_valid && !iss_ready) begin
      lock_d    = 1'b1;
      lock_oh_d = sel_oh;
    end else if (iss_fire) begin
      lock_d = 1'b0;
    end
  end

  always_comb begin
    if (flush) occ_d = '0;
    else       occ_d = occ_q + OCC_W'(disp_fire) - OCC_W'(iss_fire);
  end

  // Only control state is reset; payload fields are qualified by valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i].valid <= 1'b0;
      lock_q <= 1'b0;
      occ_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      lock_q <= lock_d;
      occ_q  <= occ_d;
    end
    lock_oh_q <= lock_oh_d;
  end
endmodule

// File: tb/tb_reservation_station.sv
module tb_reservation_station;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        disp_valid = 1'b0;
  logic        disp_ready;
  logic [2:0]  disp_tag = '0;
  logic [2:0]  disp_op = '0;
  logic [1:0]  disp_src_rdy = '0;
  logic [5:0]  disp_src_tag = '0;
  logic [63:0] disp_src_val = '0;
  logic        cdb_valid = 1'b0;
  logic [2:0]  cdb_tag = '0;
  logic [31:0] cdb_data = '0;
  logic        iss_valid;
  logic        iss_ready = 1'b0;
  logic [2:0]  iss_tag;
  logic [2:0]  iss_op;
  logic [31:0] iss_a;
  logic [31:0] iss_b;
  logic [3:0]  occupancy;

  typedef struct {
    logic [2:0]  tag;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  reservation_station dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_tag(disp_tag),
    .disp_op(disp_op), .disp_src_rdy(disp_src_rdy), .disp_src_tag(disp_src_tag),
    .disp_src_val(disp_src_val), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_tag(iss_tag), .iss_op(iss_op), .iss_a(iss_a), .iss_b(iss_b),
    .occupancy(occupancy)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [2:0] tag, input logic [2:0] op, input logic [1:0] rdy,
                      input logic [2:0] t0, input logic [2:0] t1,
                      input logic [31:0] a, input logic [31:0] b);
    disp_valid   = 1'b1;
    disp_tag     = tag;
    disp_op      = op;
    disp_src_rdy = rdy;
    disp_src_tag = {t1, t0};
    disp_src_val = {b, a};
  endtask

  task automatic push(input logic [2:0] tag, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.tag = tag; e.op = op; e.a = a; e.b = b;
    sb.push_back(e);
  endtask

  task automatic cmp_payload(input string name, input exp_t e);
    chk({name, "_tag"}, 64'(iss_tag), 64'(e.tag));
    chk({name, "_op"},  64'(iss_op),  64'(e.op));
    chk({name, "_a"},   64'(iss_a),   64'(e.a));
    chk({name, "_b"},   64'(iss_b),   64'(e.b));
  endtask

  // Wait (bounded) for an issue request, compare against the scoreboard head, accept it.
  task automatic issue_check(input string name);
    int   n;
    exp_t e;
    n = 0;
    while (iss_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_valid"}, 64'(iss_valid), 64'd1);
    if (iss_valid === 1'b1) begin
      chk({name, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        cmp_payload(name, e);
      end
      iss_ready = 1'b1;
      tick();
      iss_ready = 1'b0;
      #1;
    end
  endtask

  initial begin
    exp_t e;

    // Reset and empty state
    tick();
    chk("rst_disp_ready", 64'(disp_ready), 64'd0);
    chk("rst_iss_valid",  64'(iss_valid),  64'd0);
    chk("rst_occ",        64'(occupancy),  64'd0);
    chk("rst_iss_a",      64'(iss_a),      64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_disp_ready", 64'(disp_ready), 64'd1);
    chk("post_rst_occ",        64'(occupancy),  64'd0);

    // Ready dispatch issues one cycle later
    disp(3'd5, 3'd2, 2'b11, 3'd0, 3'd0, 32'd7, 32'd9);
    push(3'd5, 3'd2, 32'd7, 32'd9);
    tick();
    disp_valid = 1'b0;
    #1;
    chk("ready_iss_valid", 64'(iss_valid), 64'd1);
    chk("ready_occ",       64'(occupancy), 64'd1);
    issue_check("ready");
    chk("ready_occ_after", 64'(occupancy), 64'd0);
    chk("ready_empty",     64'(iss_valid), 64'd0);

    // Wakeup of a waiting entry and dispatch bypass on the same broadcast
    disp(3'd1, 3'd3, 2'b10, 3'd3, 3'd0, 32'hBAD, 32'h11);
    tick();
    disp_valid = 1'b0;
    #1;
    chk("wake_wait", 64'(iss_valid), 64'd0);
    disp(3'd2, 3'd4, 2'b01, 3'd0, 3'd3, 32'h22, 32'hBAD);
    cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 32'hDEAD;
    push(3'd1, 3'd3, 32'hDEAD, 32'h11);
    push(3'd2, 3'd4, 32'h22, 32'hDEAD);
    tick();
    disp_valid = 1'b0; cdb_valid = 1'b0;
    #1;
    issue_check("wake_a");
    issue_check("wake_b");
    chk("wake_occ", 64'(occupancy), 64'd0);

    // Age and stall lock
    disp(3'd6, 3'd1, 2'b10, 3'd1, 3'd0, 32'h0, 32'h33);
    tick();
    disp(3'd7, 3'd5, 2'b11, 3'd0, 3'd0, 32'h44, 32'h55);
    tick();
    disp_valid = 1'b0;
    #1;
    chk("lock_pre_tag", 64'(iss_tag), 64'd7);
    cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 32'h99;
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("lock_hold1_tag", 64'(iss_tag), 64'd7);
    tick();
    chk("lock_hold2_tag", 64'(iss_tag), 64'd7);
    chk("lock_hold2_a",   64'(iss_a),   64'h44);
    push(3'd7, 3'd5, 32'h44, 32'h55);
    push(3'd6, 3'd1, 32'h99, 32'h33);
    issue_check("lock_b");
    issue_check("lock_a");

    // Fill, drop when full, free one, then dispatch and issue together
    for (int i = 0; i < 8; i++) begin
      disp(3'(i), 3'(i), 2'b11, 3'd0, 3'd0, 32'(i * 16), 32'(i + 100));
      push(3'(i), 3'(i), 32'(i * 16), 32'(i + 100));
      tick();
    end
    disp_valid = 1'b0;
    #1;
    chk("full_occ",        64'(occupancy),  64'd8);
    chk("full_disp_ready", 64'(disp_ready), 64'd0);
    disp(3'd3, 3'd7, 2'b11, 3'd0, 3'd0, 32'hFFF, 32'hFFF);
    tick();
    disp_valid = 1'b0;
    #1;
    chk("full_drop_occ", 64'(occupancy), 64'd8);
    issue_check("full_0");
    chk("full_free_ready", 64'(disp_ready), 64'd1);
    chk("full_free_occ",   64'(occupancy),  64'd7);
    chk("both_valid", 64'(iss_valid), 64'd1);
    e = sb.pop_front();
    cmp_payload("both", e);
    disp(3'd0, 3'd0, 2'b11, 3'd0, 3'd0, 32'h500, 32'h501);
    push(3'd0, 3'd0, 32'h500, 32'h501);
    iss_ready = 1'b1;
    tick();
    disp_valid = 1'b0; iss_ready = 1'b0;
    #1;
    chk("both_occ", 64'(occupancy), 64'd7);
    for (int i = 0; i < 7; i++) issue_check("drain");
    chk("drain_occ", 64'(occupancy), 64'd0);

    // Flush during a stall
    disp(3'd4, 3'd2, 2'b11, 3'd0, 3'd0, 32'd1, 32'd2);
    tick();
    disp_valid = 1'b0;
    #1;
    chk("fl_pre_valid", 64'(iss_valid), 64'd1);
    tick();
    flush = 1'b1; iss_ready = 1'b1;
    disp(3'd5, 3'd1, 2'b11, 3'd0, 3'd0, 32'd3, 32'd4);
    #1;
    chk("fl_disp_ready", 64'(disp_ready), 64'd0);
    tick();
    flush = 1'b0; disp_valid = 1'b0; iss_ready = 1'b0;
    #1;
    chk("fl_occ",   64'(occupancy), 64'd0);
    chk("fl_valid", 64'(iss_valid), 64'd0);
    chk("fl_tag",   64'(iss_tag),   64'd0);
    tick();
    tick();
    chk("fl_dropped", 64'(iss_valid), 64'd0);

    // Reset during a stall
    disp(3'd4, 3'd2, 2'b11, 3'd0, 3'd0, 32'd1, 32'd2);
    tick();
    disp_valid = 1'b0;
    #1;
    chk("rs_pre_valid", 64'(iss_valid), 64'd1);
    tick();
    rst = 1'b1; iss_ready = 1'b1;
    disp(3'd5, 3'd1, 2'b11, 3'd0, 3'd0, 32'd3, 32'd4);
    #1;
    chk("rs_disp_ready", 64'(disp_ready), 64'd0);
    tick();
    rst = 1'b0; disp_valid = 1'b0; iss_ready = 1'b0;
    #1;
    chk("rs_occ",        64'(occupancy),  64'd0);
    chk("rs_valid",      64'(iss_valid),  64'd0);
    chk("rs_disp_ready_after", 64'(disp_ready), 64'd1);
    tick();
    tick();
    chk("rs_dropped", 64'(iss_valid), 64'd0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
